// File: rtl/pipeline_handshake_adapter_pkg.sv
// Shared defaults and configuration helpers for the pipeline handshake adapter.
package pipeline_handshake_adapter_pkg;

  localparam int unsigned DEF_IN_W    = 32'd32;
  localparam int unsigned DEF_OUT_W   = 32'd32;
  localparam int unsigned DEF_LATENCY = 32'd2;
  localparam int unsigned DEF_DEPTH   = 32'd4;

  function automatic bit cfg_legal(input int unsigned latency, input int unsigned depth);
    return (latency >= 32'd1) && (depth >= 32'd1);
  endfunction

endpackage

// File: rtl/pipeline_handshake_adapter_if.sv
// Request/result valid-ready bundle between the adapter and its producer/consumer.
import pipeline_handshake_adapter_pkg::*;

interface pipeline_handshake_adapter_if #(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/pipeline_handshake_adapter_fifo.sv
// Synchronous result FIFO with binary pointers wrapping at DEPTH (any DEPTH >= 1).
import pipeline_handshake_adapter_pkg::*;

module pipeline_handshake_adapter_fifo #(
  parameter int unsigned W     = DEF_OUT_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [W-1:0]  mem_r [DEPTH];
  logic          pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign pop_s = pop && !empty;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Head presentation, forced to zero when empty
  always_comb begin
    rdata = {W{1'b0}};
    if (!empty) begin
      rdata = mem_r[rd_ptr_r];
    end else begin
      rdata = {W{1'b0}};
    end
  end

endmodule

// File: rtl/pipeline_handshake_adapter.sv
// Valid/ready wrapper around a fixed-latency, non-stalling pipeline; credits
// guarantee every in-flight result has a reserved FIFO slot.
import pipeline_handshake_adapter_pkg::*;

module pipeline_handshake_adapter_chk #(
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CW      = 3
) (
  input logic               clk,
  input logic               rst_n,
  input logic               push,
  input logic               full,
  input logic [CW-1:0]      credits,
  input logic [CW-1:0]      count,
  input logic [LATENCY-1:0] vld_sr
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("result pushed into a full FIFO");

  a_credit_sum: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(credits) + 32'($countones(vld_sr)) + 32'(count)) == DEPTH)
    else $error("credits + inflight + fifo count drifted from DEPTH");

endmodule

module pipeline_handshake_adapter #(
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_handshake_adapter_if.slave  hs,
  output logic [IN_W-1:0]              pipe_in_data,
  input  logic [OUT_W-1:0]             pipe_out_data
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (!cfg_legal(LATENCY, DEPTH)) begin : g_cfg_err
    $error("pipeline_handshake_adapter: LATENCY and DEPTH must both be >= 1");
  end

  logic [CW-1:0]      credits_r;
  logic [LATENCY-1:0] vld_sr_r;
  logic [LATENCY-1:0] vld_nxt_s;
  logic               accept_s;
  logic               pop_s;
  logic               push_s;
  logic [CW-1:0]      fifo_count_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  assign pipe_in_data = hs.in_data;
  assign hs.in_ready  = (credits_r != {CW{1'b0}});
  assign accept_s     = hs.in_valid && hs.in_ready;
  assign pop_s        = hs.out_valid && hs.out_ready;
  assign push_s       = vld_sr_r[LATENCY-1];
  assign hs.out_valid = !fifo_empty_s;
  assign hs.busy      = (|vld_sr_r) || !fifo_empty_s;

  // Shift the accept flag along with its payload; written this way LATENCY=1 works too
  always_comb begin
    vld_nxt_s    = vld_sr_r << 1'b1;
    vld_nxt_s[0] = accept_s;
  end

  // Credit counter and in-flight tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r <= CW'(DEPTH);
      vld_sr_r  <= {LATENCY{1'b0}};
    end else begin
      vld_sr_r <= vld_nxt_s;
      case ({accept_s, pop_s})
        2'b10:   credits_r <= credits_r - CW'(1);
        2'b01:   credits_r <= credits_r + CW'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  pipeline_handshake_adapter_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (pipe_out_data),
    .rdata (hs.out_data),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  pipeline_handshake_adapter_chk #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .CW      (CW)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .full    (fifo_full_s),
    .credits (credits_r),
    .count   (fifo_count_s),
    .vld_sr  (vld_sr_r)
  );

endmodule

// File: tb/tb_pipeline_handshake_adapter.sv
// Scoreboard bench: two adapters (LATENCY=2/DEPTH=4 and LATENCY=3/DEPTH=1) around +7 pipelines.
module tb_pipeline_handshake_adapter;
  import pipeline_handshake_adapter_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          avail;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_handshake_adapter_if #(.IN_W(32), .OUT_W(32)) ifa ();
  pipeline_handshake_adapter_if #(.IN_W(32), .OUT_W(32)) ifb ();

  logic [31:0] pin_a, pout_a, pin_b, pout_b;
  logic [31:0] stg_a [2];
  logic [31:0] stg_b [3];

  // Stitched harness pipelines: out = in + 7, no valid, no reset
  always @(posedge clk) begin
    stg_a[0] <= pin_a + 32'd7;
    stg_a[1] <= stg_a[0];
    stg_b[0] <= pin_b + 32'd7;
    stg_b[1] <= stg_b[0];
    stg_b[2] <= stg_b[1];
  end
  assign pout_a = stg_a[1];
  assign pout_b = stg_b[2];

  pipeline_handshake_adapter #(.IN_W(32), .OUT_W(32), .LATENCY(2), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .hs(ifa), .pipe_in_data(pin_a), .pipe_out_data(pout_a));

  pipeline_handshake_adapter #(.IN_W(32), .OUT_W(32), .LATENCY(3), .DEPTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .hs(ifb), .pipe_in_data(pin_b), .pipe_out_data(pout_b));

  ent_t exp_q [2][$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   acc_cnt [2] = '{0, 0};
  int   last_acc [2] = '{-100, -100};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: each accepted request yields in+7, visible LATENCY+1 edges-counted later, in order;
  // admission is allowed while fewer than DEPTH requests are outstanding.
  task automatic monitor(input int id, input int lat, input int depth,
                         input logic iv, input logic ir, input logic ov, input logic ordy,
                         input logic [31:0] idat, input logic [31:0] odat, input logic bsy);
    logic        exp_ov;
    logic [31:0] exp_od;
    ent_t        e;
    exp_ov = (exp_q[id].size() != 0) && (exp_q[id][0].avail <= cyc);
    exp_od = exp_ov ? exp_q[id][0].data : 32'd0;
    check($sformatf("dut%0d in_ready", id), {31'd0, ir}, {31'd0, exp_q[id].size() < depth});
    check($sformatf("dut%0d out_valid", id), {31'd0, ov}, {31'd0, exp_ov});
    check($sformatf("dut%0d out_data", id), odat, exp_od);
    check($sformatf("dut%0d busy", id), {31'd0, bsy}, {31'd0, exp_q[id].size() != 0});
    if (exp_ov && ordy) begin
      void'(exp_q[id].pop_front());
    end
    if (iv && ir) begin
      if (id == 1) begin
        check("dut1 accept spacing>=4", {31'd0, (cyc - last_acc[id]) >= 4}, 32'd1);
      end
      e.data  = idat + 32'd7;
      e.avail = cyc + 1 + lat;
      exp_q[id].push_back(e);
      last_acc[id] = cyc;
      acc_cnt[id]++;
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (rst_n) begin
      monitor(0, 2, 4, ifa.in_valid, ifa.in_ready, ifa.out_valid, ifa.out_ready,
              ifa.in_data, ifa.out_data, ifa.busy);
      monitor(1, 3, 1, ifb.in_valid, ifb.in_ready, ifb.out_valid, ifb.out_ready,
              ifb.in_data, ifb.out_data, ifb.busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"}, {31'd0, ifa.in_ready}, 32'd1);
    check({tag, " out_valid"}, {31'd0, ifa.out_valid}, 32'd0);
    check({tag, " out_data"}, ifa.out_data, 32'd0);
    check({tag, " busy"}, {31'd0, ifa.busy}, 32'd0);
  endtask

  initial begin
    int n0;
    ifa.in_valid = 1'b0; ifa.in_data = 32'd0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 32'd0; ifb.out_ready = 1'b0;

    // Reset values
    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    // 1: streaming with 0,1,2,... and an always-ready consumer
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = i;
      step();
    end
    ifa.in_valid = 1'b0;
    repeat (6) step();

    // 2: consumer stalled, 10 offers -> exactly DEPTH accepted, then release
    ifa.out_ready = 1'b0;
    n0 = acc_cnt[0];
    for (int i = 0; i < 10; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = $urandom;
      step();
    end
    check("stall accepted count", acc_cnt[0] - n0, 32'd4);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ifa.in_data = $urandom;
      step();
    end

    // 3: fill to zero credits, then pop and offer together
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 8 && ifa.in_ready; i++) begin
      ifa.in_data = $urandom;
      step();
    end
    check("credits exhausted", {31'd0, ifa.in_ready}, 32'd0);
    repeat (3) step();
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ifa.in_data = $urandom;
      step();
    end
    ifa.in_valid = 1'b0;
    repeat (6) step();

    // 4: single result held under a long stall
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 32'hFFFF_FFFC;
    step();
    ifa.in_valid = 1'b0;
    repeat (20) step();
    check("held busy", {31'd0, ifa.busy}, 32'd1);
    ifa.out_ready = 1'b1;
    step();
    ifa.out_ready = 1'b0;
    step();
    check("busy after pop", {31'd0, ifa.busy}, 32'd0);

    // 5: reset with results both buffered and in flight
    for (int i = 0; i < 4; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = 32'h100 + i;
      step();
    end
    ifa.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_idle("mid reset");
    exp_q[0].delete();
    exp_q[1].delete();
    step();
    rst_n = 1'b1;
    repeat (4) step();

    // 6: random traffic on both adapters
    for (int i = 0; i < 400; i++) begin
      ifa.in_valid  = ($urandom_range(3) != 0);
      ifa.in_data   = $urandom;
      ifa.out_ready = ($urandom_range(2) != 0);
      ifb.in_valid  = ($urandom_range(1) != 0);
      ifb.in_data   = $urandom;
      ifb.out_ready = ($urandom_range(2) != 0);
      step();
    end

    // Drain and confirm nothing is left outstanding
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    repeat (12) step();
    check("dut0 drained", exp_q[0].size(), 32'd0);
    check("dut1 drained", exp_q[1].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
